// File: rtl/rm_symbol_feeder.sv
// rm_symbol_feeder: producer end of the runtime-monitor symbol interface.
// Buffers core trace-event symbols in a FIFO, streams them one per cycle to
// the monitor cluster, and sequences the cluster reset (power-on pulse and
// drain-then-reset restart).
//
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   ev_valid       core offers ev_symbol
//   ev_symbol      offered symbol
//   ev_ready       combinational accept (STREAM state and FIFO not full)
//   enable         permit streaming while in STREAM
//   restart_req    one-cycle request: drain FIFO, then reset the monitor
//   symbols        registered symbol to the monitor
//   run            registered qualifier, symbols valid this cycle
//   mon_reset      registered reset to the monitor cluster
//   restart_done   one-cycle pulse when a reset sequence completes
//   fifo_level     current FIFO occupancy
//   sym_count      cycles with run=1, modulo 2^CNT_W
module rm_symbol_feeder #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned SYM_W      = 8,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ev_valid,
  input  logic [SYM_W-1:0]         ev_symbol,
  output logic                     ev_ready,
  input  logic                     enable,
  input  logic                     restart_req,
  output logic [SYM_W-1:0]         symbols,
  output logic                     run,
  output logic                     mon_reset,
  output logic                     restart_done,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         sym_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned RC_W  = $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_MRESET,
    ST_STREAM,
    ST_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic              mon_reset_d;
  logic              restart_done_d;
  logic              pop_en;
  logic              push;
  logic              pop;

  logic [SYM_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  assign push = ev_valid && ev_ready;
  assign pop  = pop_en && (fifo_level != '0);

  // State register plus the registered reset-sequencer outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_MRESET;
      rst_cnt_q    <= RC_W'(RST_CYCLES);
      mon_reset    <= 1'b1;
      restart_done <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      mon_reset    <= mon_reset_d;
      restart_done <= restart_done_d;
    end
  end

  // Next-state, accept and pop-permit logic.
  always_comb begin
    state_d        = state_q;
    rst_cnt_d      = rst_cnt_q;
    mon_reset_d    = mon_reset;
    restart_done_d = 1'b0;
    ev_ready       = 1'b0;
    pop_en         = 1'b0;
    case (state_q)
      ST_STREAM: begin
        // Full check ignores a same-cycle pop, so a full FIFO never pushes.
        ev_ready = (fifo_level != LVL_W'(DEPTH));
        pop_en   = enable;
        if (restart_req) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        pop_en = 1'b1;
        // No pushes in DRAIN and level 1 always pops, so this is "empty after this edge".
        if (fifo_level <= LVL_W'(1)) begin
          state_d     = ST_MRESET;
          rst_cnt_d   = RC_W'(RST_CYCLES);
          mon_reset_d = 1'b1;
        end
      end
      ST_MRESET: begin
        rst_cnt_d = rst_cnt_q - RC_W'(1);
        if (rst_cnt_q == RC_W'(1)) begin
          state_d        = ST_STREAM;
          mon_reset_d    = 1'b0;
          restart_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_MRESET;
      end
    endcase
  end

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= ev_symbol;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of 2).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Registered symbol stream and issued-symbol counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      symbols   <= '0;
      run       <= 1'b0;
      sym_count <= '0;
    end else begin
      run <= pop;
      if (pop) begin
        symbols   <= mem[rd_ptr];
        sym_count <= sym_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rm_symbol_feeder.sv
// Randomized self-checking bench for rm_symbol_feeder against a queue-based
// behavioural model of the feeder.
module tb_rm_symbol_feeder;

  localparam int unsigned DEPTH      = 8;
  localparam int unsigned SYM_W      = 8;
  localparam int unsigned RST_CYCLES = 4;
  localparam int unsigned CNT_W      = 16;
  localparam int          CNT_MOD    = 1 << CNT_W;

  logic             clk;
  logic             reset;
  logic             ev_valid;
  logic [SYM_W-1:0] ev_symbol;
  logic             ev_ready;
  logic             enable;
  logic             restart_req;
  logic [SYM_W-1:0] symbols;
  logic             run;
  logic             mon_reset;
  logic             restart_done;
  logic [3:0]       fifo_level;
  logic [CNT_W-1:0] sym_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mode 0 = monitor reset, 1 = streaming, 2 = draining.
  bit [SYM_W-1:0] mq[$];
  int             m_mode;
  int             m_left;
  bit             m_run;
  bit [SYM_W-1:0] m_sym;
  bit             m_mon;
  bit             m_done;
  int             m_cnt;

  rm_symbol_feeder #(
    .DEPTH(DEPTH), .SYM_W(SYM_W), .RST_CYCLES(RST_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .ev_valid(ev_valid), .ev_symbol(ev_symbol),
    .ev_ready(ev_ready), .enable(enable), .restart_req(restart_req),
    .symbols(symbols), .run(run), .mon_reset(mon_reset),
    .restart_done(restart_done), .fifo_level(fifo_level), .sym_count(sym_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_mode = 0;
    m_left = RST_CYCLES;
    m_run  = 1'b0;
    m_sym  = '0;
    m_mon  = 1'b1;
    m_done = 1'b0;
    m_cnt  = 0;
  endtask

  function automatic bit m_ready();
    return (m_mode == 1) && (mq.size() < DEPTH);
  endfunction

  task automatic model_edge(input bit v, input bit [SYM_W-1:0] s, input bit en,
                            input bit rr, output bit acc);
    bit pop;
    acc    = v && m_ready();
    pop    = (mq.size() > 0) && (m_mode == 2 || (m_mode == 1 && en));
    m_done = 1'b0;
    m_run  = pop;
    if (pop) begin
      m_sym = mq.pop_front();
      m_cnt = (m_cnt + 1) % CNT_MOD;
    end
    if (acc) mq.push_back(s);
    case (m_mode)
      1: if (rr) m_mode = 2;
      2: if (mq.size() == 0) begin
           m_mode = 0;
           m_left = RST_CYCLES;
           m_mon  = 1'b1;
         end
      default: begin
        m_left--;
        if (m_left == 0) begin
          m_mode = 1;
          m_mon  = 1'b0;
          m_done = 1'b1;
        end
      end
    endcase
  endtask

  task automatic check_outputs();
    check("run",          32'(run),          32'(m_run));
    check("symbols",      32'(symbols),      32'(m_sym));
    check("mon_reset",    32'(mon_reset),    32'(m_mon));
    check("restart_done", 32'(restart_done), 32'(m_done));
    check("fifo_level",   32'(fifo_level),   32'(mq.size()));
    check("sym_count",    32'(sym_count),    32'(m_cnt));
  endtask

  // One clock cycle; called at posedge+1, returns at the next posedge+1.
  task automatic cycle(input bit v, input bit [SYM_W-1:0] s, input bit en,
                       input bit rr, output bit acc);
    ev_valid    = v;
    ev_symbol   = s;
    enable      = en;
    restart_req = rr;
    #2;
    check("ev_ready", 32'(ev_ready), 32'(m_ready()));
    @(posedge clk);
    model_edge(v, s, en, rr, acc);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n, input bit en);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, en, 1'b0, acc);
  endtask

  // Run with enable=1 until the model is streaming with an empty FIFO.
  task automatic settle();
    int budget = 60;
    while (!(m_mode == 1 && mq.size() == 0) && budget > 0) begin
      idle(1, 1'b1);
      budget--;
    end
    if (budget == 0) check("settle_timeout", 32'd1, 32'd0);
  endtask

  task automatic apply_reset();
    reset       = 1'b1;
    ev_valid    = 1'b0;
    enable      = 1'b0;
    restart_req = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("ev_ready_rst", 32'(ev_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b0;
  endtask

  initial begin
    bit acc;
    int budget;
    ev_symbol = '0;
    @(posedge clk);
    #1;
    apply_reset();

    // Power-on sequence with no traffic.
    idle(6, 1'b0);

    // Streaming latency: three back-to-back pushes.
    settle();
    cycle(1'b1, 8'h11, 1'b1, 1'b0, acc);
    cycle(1'b1, 8'h22, 1'b1, 1'b0, acc);
    cycle(1'b1, 8'h33, 1'b1, 1'b0, acc);
    idle(3, 1'b1);

    // Fill with streaming disabled, hold a 9th offer, then release.
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, acc);
    check("full_level", 32'(fifo_level), 32'd8);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 8'hA8, 1'b0, 1'b0, acc);
      check("held_offer", 32'(acc), 32'd0);
    end
    budget = 20;
    acc    = 1'b0;
    while (!acc && budget > 0) begin
      cycle(1'b1, 8'hA8, 1'b1, 1'b0, acc);
      budget--;
    end
    if (!acc) check("accept_timeout", 32'd1, 32'd0);
    idle(12, 1'b1);

    // Restart with pending data while enable is low.
    settle();
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, acc);
    cycle(1'b0, '0, 1'b0, 1'b1, acc);
    for (int i = 0; i < 12; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b1, acc);

    // Randomized traffic with occasional restarts.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 99) < 3), acc);
    end

    // Asynchronous reset mid-drain with 4 entries queued.
    settle();
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, acc);
    cycle(1'b0, '0, 1'b0, 1'b1, acc);
    check("drain_level", 32'(fifo_level), 32'd4);
    apply_reset();
    idle(6, 1'b1);

    // Sustained push/pop across pointer wrap and sym_count wrap.
    for (int i = 0; i < CNT_MOD + 2; i++) begin
      cycle(1'b1, 8'($urandom), 1'b1, 1'b0, acc);
      if (i < 20) check("steady_accept", 32'(acc), 32'd1);
    end
    idle(2, 1'b1);
    check("count_wrap", 32'(sym_count), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
